demo_cpu_core: RTL and testbench

DEMO_CPU_CORE -- requirements
Module: demo_cpu_core

---
 rtl/demo_cpu_core.sv | 177 +++++++++++++++++
 tb/tb_demo_cpu_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_cpu_core.sv
// Minimal accumulator CPU: one-word opcode fetch, up to two operand words,
// optional memory read or store. Memory returns data one cycle after its address.
module demo_cpu_core #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clock_25,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wr,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_sync,
    output logic              o_halt
);

    typedef enum logic [3:0] {
        FETCH, OPC, LO_A, LO_D, HI_A, HI_D, MEM_A, MEM_D, STORE, HALT
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hB;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ea_q, ea_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [3:0]          ir_q, ir_d;
    logic                c_q, c_d;
    logic                z_q, z_d;

    logic [2*DATA_W-1:0] ea_full;
    logic [ADDR_W-1:0]   ea_new;
    logic [DATA_W:0]     sum_ext;
    logic [DATA_W-1:0]   alu_res;

    // High word arrives on i_data in HI_D; the low word was latched in LO_D.
    assign ea_full = {i_data, lo_q};
    assign ea_new  = ea_full[ADDR_W-1:0];

    assign o_data = a_q;
    assign o_acc  = a_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ea_d    = ea_q;
        a_d     = a_q;
        lo_d    = lo_q;
        ir_d    = ir_q;
        c_d     = c_q;
        z_d     = z_q;
        sum_ext = '0;
        alu_res = a_q;
        o_addr  = pc_q;
        o_wr    = 1'b0;
        o_sync  = 1'b0;
        o_halt  = 1'b0;

        case (state_q)
            FETCH: begin
                o_sync  = 1'b1;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = OPC;
            end
            OPC: begin
                ir_d = i_data[3:0];
                if (i_data[3:0] == OP_HLT)
                    state_d = HALT;
                else if (i_data[3:0] >= OP_LDI && i_data[3:0] <= OP_JC)
                    state_d = LO_A;
                else
                    state_d = FETCH;
            end
            LO_A: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = LO_D;
            end
            LO_D: begin
                lo_d = i_data;
                if (ir_q == OP_LDI) begin
                    a_d     = i_data;
                    z_d     = (i_data == '0);
                    state_d = FETCH;
                end else begin
                    state_d = HI_A;
                end
            end
            HI_A: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = HI_D;
            end
            HI_D: begin
                ea_d    = ea_new;
                state_d = MEM_A;
                case (ir_q)
                    OP_JMP: begin pc_d = ea_new; state_d = FETCH; end
                    OP_JZ:  begin if (z_q) pc_d = ea_new; state_d = FETCH; end
                    OP_JC:  begin if (c_q) pc_d = ea_new; state_d = FETCH; end
                    OP_STA: state_d = STORE;
                    default: ;
                endcase
            end
            MEM_A: begin
                o_addr  = ea_q;
                state_d = MEM_D;
            end
            MEM_D: begin
                o_addr = ea_q;
                case (ir_q)
                    OP_LDA: alu_res = i_data;
                    OP_ADD: begin
                        sum_ext = {1'b0, a_q} + {1'b0, i_data};
                        alu_res = sum_ext[DATA_W-1:0];
                        c_d     = sum_ext[DATA_W];
                    end
                    OP_SUB: begin
                        // Carry out of A + ~M + 1 is the inverted borrow.
                        sum_ext = {1'b0, a_q} + {1'b0, ~i_data} + {{DATA_W{1'b0}}, 1'b1};
                        alu_res = sum_ext[DATA_W-1:0];
                        c_d     = sum_ext[DATA_W];
                    end
                    OP_AND: alu_res = a_q & i_data;
                    OP_OR:  alu_res = a_q | i_data;
                    default: ;
                endcase
                a_d     = alu_res;
                z_d     = (alu_res == '0);
                state_d = FETCH;
            end
            STORE: begin
                o_addr  = ea_q;
                o_wr    = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                o_halt = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_VEC;
            ea_q    <= '0;
            a_q     <= '0;
            lo_q    <= '0;
            ir_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ea_q    <= ea_d;
            a_q     <= a_d;
            lo_q    <= lo_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_demo_cpu_core.sv
// Bench for demo_cpu_core: directed programs plus random programs checked
// against an instruction-level model of the ISA.
module tb_demo_cpu_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  i_data, o_data, o_acc;
    logic [15:0] o_addr;
    logic        o_wr, o_sync, o_halt;

    logic [7:0]  i_data2, o_data2, o_acc2;
    logic [15:0] o_addr2;
    logic        o_wr2, o_sync2, o_halt2;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    demo_cpu_core #(.DATA_W(8), .ADDR_W(16), .RESET_VEC(16'h0000)) u_dut (
        .clock_25(clk), .reset_n(reset_n), .i_data(i_data), .o_addr(o_addr),
        .o_data(o_data), .o_wr(o_wr), .o_acc(o_acc), .o_sync(o_sync), .o_halt(o_halt)
    );

    // Second core only exercises PC wrap from the top of the address space.
    demo_cpu_core #(.DATA_W(8), .ADDR_W(16), .RESET_VEC(16'hFFFF)) u_dut_vec (
        .clock_25(clk), .reset_n(reset_n), .i_data(i_data2), .o_addr(o_addr2),
        .o_data(o_data2), .o_wr(o_wr2), .o_acc(o_acc2), .o_sync(o_sync2), .o_halt(o_halt2)
    );

    // Registered read gives the one-cycle latency; a write lands at the STORE edge.
    always @(posedge clk) begin
        i_data <= mem[o_addr];
        if (o_wr) mem[o_addr] = o_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic next_sync(output logic [15:0] addr, output logic [7:0] acc, output int at);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_sync && n < 64);
        chk("sync_seen", o_sync, 1);
        addr = o_addr;
        acc  = o_acc;
        at   = cyc;
    endtask

    // Instruction-level model: executes one instruction per sync, predicts
    // its length, bus write and resulting architectural state.
    task automatic run_model(input int max_ins);
        logic [15:0] pc, pc0, p1, p2, ea;
        logic [7:0]  a, a0, m;
        logic [3:0]  op;
        logic        c, z, halted, st;
        int          ncyc, t;
        pc = 16'h0000; a = 8'h00; c = 1'b0; z = 1'b0; halted = 1'b0;
        for (int n = 0; n < max_ins && !halted; n++) begin
            pc0 = pc; a0 = a;
            p1 = pc + 16'd1; p2 = pc + 16'd2;
            op = ref_mem[pc][3:0];
            ea = {ref_mem[p2], ref_mem[p1]};
            m  = ref_mem[ea];
            st = 1'b0;
            ncyc = 2;
            pc = p1;
            case (op)
                4'h1: begin a = ref_mem[p1]; z = (a == 0); pc = p2; ncyc = 4; end
                4'h2: begin a = m; z = (a == 0); pc = pc0 + 16'd3; ncyc = 8; end
                4'h3: begin st = 1'b1; pc = pc0 + 16'd3; ncyc = 7; end
                4'h4: begin
                    t = int'(a) + int'(m); c = (t > 255); a = 8'(t); z = (a == 0);
                    pc = pc0 + 16'd3; ncyc = 8;
                end
                4'h5: begin
                    t = int'(a) - int'(m); c = (t >= 0); a = 8'(t); z = (a == 0);
                    pc = pc0 + 16'd3; ncyc = 8;
                end
                4'h6: begin a = a & m; z = (a == 0); pc = pc0 + 16'd3; ncyc = 8; end
                4'h7: begin a = a | m; z = (a == 0); pc = pc0 + 16'd3; ncyc = 8; end
                4'h8: begin pc = ea; ncyc = 6; end
                4'h9: begin pc = z ? ea : pc0 + 16'd3; ncyc = 6; end
                4'hA: begin pc = c ? ea : pc0 + 16'd3; ncyc = 6; end
                4'hB: halted = 1'b1;
                default: ;
            endcase
            chk("rnd_sync", o_sync, 1);
            chk("rnd_pc", o_addr, pc0);
            chk("rnd_acc", o_acc, a0);
            chk("rnd_halt", o_halt, 0);
            for (int k = 1; k < ncyc; k++) begin
                step();
                chk("rnd_wr", o_wr, (st && k == 6));
                if (st && k == 6) begin
                    chk("rnd_wr_addr", o_addr, ea);
                    chk("rnd_wr_data", o_data, a);
                end
            end
            if (st) ref_mem[ea] = a;
            step();
        end
        if (halted) begin
            for (int k = 0; k < 3; k++) begin
                chk("rnd_halted", o_halt, 1);
                chk("rnd_halt_pc", o_addr, pc);
                chk("rnd_halt_wr", o_wr, 0);
                chk("rnd_halt_sync", o_sync, 0);
                step();
            end
        end
    endtask

    initial begin
        logic [15:0] sa;
        logic [7:0]  sacc;
        int          st;
        reset_n = 1'b0;
        i_data2 = 8'h00;

        // LDI 2Fh; STA 0516h, with reset-state and vector-wrap checks
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h2F; mem[2] = 8'h03; mem[3] = 8'h16; mem[4] = 8'h05;
        do_reset();
        chk("rst_addr", o_addr, 16'h0000);
        chk("rst_sync", o_sync, 1);
        chk("rst_wr", o_wr, 0);
        chk("rst_halt", o_halt, 0);
        chk("rst_acc", o_acc, 8'h00);
        chk("vec_addr", o_addr2, 16'hFFFF);
        chk("vec_sync", o_sync2, 1);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("sta_wr_c%0d", cyc), o_wr, (cyc == 10));
            if (cyc == 10) begin
                chk("sta_addr", o_addr, 16'h0516);
                chk("sta_data", o_data, 8'h2F);
            end
            if (cyc == 2) begin
                chk("vec_wrap_sync", o_sync2, 1);
                chk("vec_wrap_addr", o_addr2, 16'h0000);
            end
            step();
        end
        chk("sta_mem", mem[16'h0516], 8'h2F);

        // Same program, reset dropped in HI_D of the STA
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h2F; mem[2] = 8'h03; mem[3] = 8'h16; mem[4] = 8'h05;
        do_reset();
        repeat (9) step();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sta_wr", o_wr, 0);
        end
        reset_n = 1'b1;
        cyc = 0;
        chk("rst_sta_addr", o_addr, 16'h0000);
        chk("rst_sta_acc", o_acc, 8'h00);
        step();
        chk("rst_sta_mem", mem[16'h0516], 8'h00);

        // LDI FFh; ADD [0100h]=01h; JC 0300h; JZ 0400h
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'hFF; mem[2] = 8'h04; mem[3] = 8'h00; mem[4] = 8'h01;
        mem[5] = 8'h0A; mem[6] = 8'h00; mem[7] = 8'h03; mem[16'h0100] = 8'h01;
        mem[16'h0300] = 8'h09; mem[16'h0301] = 8'h00; mem[16'h0302] = 8'h04;
        do_reset();
        next_sync(sa, sacc, st); chk("add_s1", sa, 16'h0002); chk("add_t1", st, 4);
        next_sync(sa, sacc, st); chk("add_s2", sa, 16'h0005); chk("add_t2", st, 12);
        chk("add_acc", sacc, 8'h00);
        next_sync(sa, sacc, st); chk("add_jc", sa, 16'h0300); chk("add_t3", st, 18);
        next_sync(sa, sacc, st); chk("add_jz", sa, 16'h0400); chk("add_t4", st, 24);

        // LDI 05h; SUB [0100h]=07h; JC and JZ both fall through; HLT
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h05; mem[3] = 8'h00; mem[4] = 8'h01;
        mem[5] = 8'h0A; mem[6] = 8'h00; mem[7] = 8'h03;
        mem[8] = 8'h09; mem[9] = 8'h00; mem[10] = 8'h04; mem[11] = 8'h0B;
        mem[16'h0100] = 8'h07;
        do_reset();
        next_sync(sa, sacc, st);
        next_sync(sa, sacc, st); chk("sub_acc", sacc, 8'hFE);
        next_sync(sa, sacc, st); chk("sub_jc", sa, 16'h0008); chk("sub_t3", st, 18);
        next_sync(sa, sacc, st); chk("sub_jz", sa, 16'h000B); chk("sub_t4", st, 24);
        step(); step();
        chk("sub_halt", o_halt, 1);
        chk("sub_halt_pc", o_addr, 16'h000C);

        // LDI 00h; JZ 0200h taken
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h09; mem[3] = 8'h00; mem[4] = 8'h02;
        do_reset();
        next_sync(sa, sacc, st);
        next_sync(sa, sacc, st); chk("jz_taken", sa, 16'h0200); chk("jz_t", st, 10);

        // LDI 01h; NOPs; JZ 0200h at 0007h not taken
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h01; mem[7] = 8'h09; mem[8] = 8'h00; mem[9] = 8'h02;
        do_reset();
        for (int i = 0; i < 6; i++) next_sync(sa, sacc, st);
        chk("jz_at", sa, 16'h0007);
        next_sync(sa, sacc, st); chk("jz_fall", sa, 16'h000A); chk("jz_fall_t", st, 20);

        // HLT at 0000h
        clear_mem();
        mem[0] = 8'h0B;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("hlt_halt_c%0d", cyc), o_halt, (cyc >= 2));
            chk($sformatf("hlt_sync_c%0d", cyc), o_sync, (cyc == 0));
            chk("hlt_wr", o_wr, 0);
            if (cyc >= 1) chk("hlt_addr", o_addr, 16'h0001);
            step();
        end

        // Random programs over the full address space
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 65536; i++) begin
                mem[i]     = 8'($urandom);
                ref_mem[i] = mem[i];
            end
            do_reset();
            run_model(200);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
